// File: rtl/regfile_write_demux_pkg.sv
// Shared constants for the register-file write side.
// The read-mux trees and the hazard unit import the same package, so the
// geometry of the register file is defined in exactly one place.
//   WIDTH     : data width of each architectural register
//   ADDR_BITS : register index width
//   NUM_REGS  : number of architectural registers (2**ADDR_BITS)
//   ZERO_REG  : index of the register that always reads as zero
package regfile_write_demux_pkg;

  localparam int WIDTH     = 64;
  localparam int ADDR_BITS = 5;
  localparam int NUM_REGS  = 2 ** ADDR_BITS;
  localparam int ZERO_REG  = 31;

  // A write only lands when it is requested and does not target the
  // constant-zero register.
  function automatic logic write_commits(input logic en, input logic [ADDR_BITS-1:0] addr);
    return en && (addr != ADDR_BITS'(ZERO_REG));
  endfunction

endpackage

// File: rtl/regfile_write_demux_decoder.sv
// Hierarchical 5-to-32 one-hot decoder, built like the read-side mux trees:
// a 2-to-4 stage on addr[4:3] enables one of four 3-to-8 stages on addr[2:0].
//   decoder2_4  : en_i, addr_i[1:0] -> onehot_o[3:0]
//   decoder3_8  : en_i, addr_i[2:0] -> onehot_o[7:0]
//   decoder5_32 : en_i, addr_i[4:0] -> onehot_o[31:0]
// All outputs are zero when en_i is low.

module decoder2_4 (
  input  logic       en_i,
  input  logic [1:0] addr_i,
  output logic [3:0] onehot_o
);
  assign onehot_o = en_i ? (4'b0001 << addr_i) : 4'b0000;
endmodule

module decoder3_8 (
  input  logic       en_i,
  input  logic [2:0] addr_i,
  output logic [7:0] onehot_o
);
  assign onehot_o = en_i ? (8'b0000_0001 << addr_i) : 8'b0000_0000;
endmodule

module decoder5_32 (
  input  logic        en_i,
  input  logic [4:0]  addr_i,
  output logic [31:0] onehot_o
);
  logic [3:0] bank_en;

  decoder2_4 u_bank (
    .en_i     (en_i),
    .addr_i   (addr_i[4:3]),
    .onehot_o (bank_en)
  );

  for (genvar b = 0; b < 4; b++) begin : g_bank
    decoder3_8 u_sub (
      .en_i     (bank_en[b]),
      .addr_i   (addr_i[2:0]),
      .onehot_o (onehot_o[b*8 +: 8])
    );
  end
endmodule

// File: rtl/regfile_write_demux.sv
// Write side of the CPU register file.
// Decodes the write address to a one-hot enable, stores wr_data into the
// selected register at the clock edge and exposes every register on a flat
// bus for the read-port mux trees. Register ZERO_REG always reads zero.
// Ports:
//   clk       : clock, all state updates on posedge
//   reset_n   : synchronous active-low reset (overrides a concurrent write)
//   wr_en     : write request from write-back
//   wr_addr   : destination register index
//   wr_data   : value to write
//   regs_flat : register i at bits [i*WIDTH +: WIDTH]
//   wr_onehot : registered one-hot of the write committed at the last edge
//   wr_done   : registered; high if a write committed at the last edge
// Handshake: there is no back-pressure. A write presented with wr_en high is
// accepted at that edge unconditionally; wr_done/wr_onehot report it one
// cycle later. The new value is visible on regs_flat right after the
// committing edge; there is no write-through, so forwarding belongs to the
// hazard unit.
module regfile_write_demux
  import regfile_write_demux_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [ADDR_BITS-1:0]      wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  output logic [NUM_REGS*WIDTH-1:0] regs_flat,
  output logic [NUM_REGS-1:0]       wr_onehot,
  output logic                      wr_done
);

  logic                commit;
  logic [NUM_REGS-1:0] sel_onehot;
  logic [NUM_REGS-1:0] wr_onehot_q;
  logic                wr_done_q;

  // Gating the decoder with the zero-register test keeps its one-hot clean,
  // so it can feed wr_onehot directly.
  assign commit = write_commits(wr_en, wr_addr);

  decoder5_32 u_dec (
    .en_i     (commit),
    .addr_i   (wr_addr),
    .onehot_o (sel_onehot)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign regs_flat[i*WIDTH +: WIDTH] = '0;
    end else begin : g_flop
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;

      assign data_d = sel_onehot[i] ? wr_data : data_q;

      always_ff @(posedge clk) begin
        if (!reset_n) data_q <= '0;
        else          data_q <= data_d;
      end

      assign regs_flat[i*WIDTH +: WIDTH] = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_onehot_q <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      wr_onehot_q <= sel_onehot;
      wr_done_q   <= commit;
    end
  end

  assign wr_onehot = wr_onehot_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_regfile_write_demux.sv
module tb_regfile_write_demux;
  import regfile_write_demux_pkg::*;

  // ---------------- clock / reset ----------------
  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      wr_en;
  logic [ADDR_BITS-1:0]      wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [NUM_REGS*WIDTH-1:0] regs_flat;
  logic [NUM_REGS-1:0]       wr_onehot;
  logic                      wr_done;

  always #5 clk = ~clk;

  regfile_write_demux dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .regs_flat (regs_flat),
    .wr_onehot (wr_onehot),
    .wr_done   (wr_done)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0]    m_regs [NUM_REGS];
  logic [NUM_REGS-1:0] m_onehot;
  logic                m_done;
  bit                  chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] slice(input int i);
    return regs_flat[i*WIDTH +: WIDTH];
  endfunction

  // ---------------- driver ----------------
  // Presents one cycle of inputs, waits for the edge, then advances the model
  // from the architectural rules of the register file.
  task automatic step(input logic rst_n, input logic en, input int addr, input logic [WIDTH-1:0] data);
    reset_n = rst_n;
    wr_en   = en;
    wr_addr = ADDR_BITS'(addr);
    wr_data = data;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
      m_onehot = '0;
      m_done   = 1'b0;
    end else if (en && addr != ZERO_REG) begin
      m_regs[addr] = data;
      m_onehot     = NUM_REGS'(1) << addr;
      m_done       = 1'b1;
    end else begin
      m_onehot = '0;
      m_done   = 1'b0;
    end
    chk_en = 1'b1;
    #1;
  endtask

  // ---------------- scoreboard compare (every cycle) ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < NUM_REGS; i++)
          check($sformatf("reg%0d", i), slice(i), m_regs[i]);
        check("wr_onehot", WIDTH'(wr_onehot), WIDTH'(m_onehot));
        check("wr_done", WIDTH'(wr_done), WIDTH'(m_done));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // 1. reset overrides a concurrent write
    step(1'b0, 1'b1, 3, 64'd5);
    for (int i = 0; i < NUM_REGS; i++) check($sformatf("t1_reg%0d", i), slice(i), '0);
    check("t1_onehot", WIDTH'(wr_onehot), '0);
    check("t1_done", WIDTH'(wr_done), '0);

    // 2. simple write
    step(1'b1, 1'b1, 7, 64'hDEAD_BEEF_0000_0001);
    check("t2_reg7", slice(7), 64'hDEAD_BEEF_0000_0001);
    check("t2_onehot", WIDTH'(wr_onehot), 64'h0000_0080);
    check("t2_done", WIDTH'(wr_done), 64'd1);
    check("t2_reg6", slice(6), '0);

    // 3. write to the zero register is discarded
    step(1'b1, 1'b1, 31, '1);
    check("t3_reg31", slice(31), '0);
    check("t3_onehot", WIDTH'(wr_onehot), '0);
    check("t3_done", WIDTH'(wr_done), '0);
    check("t3_reg7", slice(7), 64'hDEAD_BEEF_0000_0001);

    // 4. back-to-back writes to the same register
    step(1'b1, 1'b1, 2, 64'h11);
    check("t4_onehot_a", WIDTH'(wr_onehot), 64'h4);
    check("t4_reg2_a", slice(2), 64'h11);
    step(1'b1, 1'b1, 2, 64'h22);
    check("t4_onehot_b", WIDTH'(wr_onehot), 64'h4);
    check("t4_reg2_b", slice(2), 64'h22);

    // 5. wr_en low while sweeping every address
    for (int a = 0; a < NUM_REGS; a++) begin
      step(1'b1, 1'b0, a, {$urandom, $urandom});
      check("t5_done", WIDTH'(wr_done), '0);
    end
    check("t5_reg7", slice(7), 64'hDEAD_BEEF_0000_0001);
    check("t5_reg2", slice(2), 64'h22);

    // 6. fill, reset, then first write after reset commits
    for (int a = 0; a < NUM_REGS - 1; a++) step(1'b1, 1'b1, a, WIDTH'(a + 1));
    check("t6_reg30", slice(30), 64'd31);
    step(1'b0, 1'b0, 0, '0);
    for (int i = 0; i < NUM_REGS; i++) check($sformatf("t6_reg%0d", i), slice(i), '0);
    step(1'b1, 1'b1, 0, 64'd9);
    check("t6_reg0", slice(0), 64'd9);
    check("t6_onehot", WIDTH'(wr_onehot), 64'h1);

    // random traffic with occasional reset and zero-register hits
    for (int n = 0; n < 400; n++) begin
      int a;
      a = ($urandom_range(0, 7) == 0) ? ZERO_REG : $urandom_range(0, NUM_REGS - 1);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), a, {$urandom, $urandom});
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
